mc_sequencer: RTL
=================

// Module: mc_sequencer
// PURPOSE
//   Registered control sequencer for the multi-cycle MIPS core.
//   Holds the IF/ID/EX/MEM/WB state register and steps it one state per clock.
//   Stalls IF and MEM on a memory ready handshake and drives per-state datapath strobes.
//   Adds a HALT state (sampled only at instruction boundaries), a sticky ERR state
//   with memory timeout, and a retired-instruction counter.
// PARAMETERS
//   MEM_TIMEOUT  15  max consecutive cycles with mem_ready low in IF/MEM before ERR (1..255)
//   CNT_W        8   width of internal wait counter; must hold MEM_TIMEOUT
// PORTS
//   clk          in   1           core clock, all state on rising edge
//   rst_n        in   1           asynchronous, active-low reset
//   opcode       in   6           instr[31:26] from IR (valid from ID onward)
//   alu_zero     in   1           ALU zero flag (valid in EX)
//   mem_ready    in   1           memory completes current request this cycle
//   halt_req     in   1           request to stop at next instruction boundary
//   state        out  STATE_LEN   current state register
//   pc_we        out  1           PC write strobe
//   pc_src       out  2           0: PC+4, 1: branch target, 2: jump target
//   ir_we        out  1           instruction register write strobe
//   rf_we        out  1           regfile write strobe
//   mem_req      out  1           memory request (held until mem_ready)
//   mem_we       out  1           memory write (qualifies mem_req)
//   mem_ifetch   out  1           1: memory address = PC, 0: ALU result
//   retire       out  1           one-cycle pulse when an instruction completes
//   retired_cnt  out  32          count of retire pulses, wraps 0xFFFFFFFF -> 0
//   err          out  1           1 while in STATE_ERR
// BEHAVIOUR
//   - Reset: state=IF, wait_cnt=0, retired_cnt=0. While rst_n is low, all strobes
//     (pc_we, ir_we, rf_we, mem_req, mem_we, retire) are forced to 0.
//     The first fetch request is issued in the first cycle after rst_n rises.
//   - Reset asserted mid-instruction aborts it immediately. No retire is issued.
//   - Strobe outputs decode combinationally from state, plus mem_ready in IF/MEM.
//   - IF: mem_req=1, mem_ifetch=1.
//       mem_ready=1 -> ir_we=1, pc_we=1, pc_src=0, go ID.
//       Otherwise stay in IF.
//   - ID: OP_J -> pc_we=1, pc_src=2, retire, then boundary.
//       R_TYPE/ADDI/ORI/LW/SW/BEQ -> EX.
//       Any other opcode -> ERR.
//   - EX: R_TYPE/ADDI/ORI -> WB.
//       LW/SW -> MEM.
//       BEQ -> pc_we=alu_zero, pc_src=1, retire, then boundary.
//   - MEM: mem_req=1, mem_we=(opcode==OP_SW); wait for mem_ready.
//       LW -> WB.
//       SW -> retire, then boundary.
//   - WB: rf_we=1, retire, then boundary.
//   - Boundary: next state is HALT if halt_req=1, else IF.
//   - HALT: no strobes. Go to IF on the first cycle halt_req=0.
//     halt_req is ignored mid-instruction.
//   - Timeout: wait_cnt increments each IF/MEM cycle with mem_ready=0.
//     It clears on every state change and on mem_ready=1.
//     Reaching MEM_TIMEOUT -> ERR on that edge.
//     mem_ready=1 in the same cycle wins and completes normally.
//   - ERR: sticky until reset; no strobes, err=1.
//   - retired_cnt increments on the clock edge after each retire pulse
//     (one increment per retired instruction).
//   - mem_we is never 1 unless mem_req=1.
//   - At most one of ir_we/rf_we/(mem_req&mem_we) is 1 in any cycle.
// STRUCTURE
//   - defines.v gains STATE_HALT and STATE_ERR; STATE_LEN >= 3.
//   - Existing OP_* and STATE_* constants stay in defines.v.
//   - Sub-module mc_seq_decode (combinational) maps state/opcode/alu_zero/mem_ready/
//     halt_req/timeout to next_state and strobes.
//   - The top holds the state register, wait_cnt and retired_cnt.
// TESTING
//   - ADDI, mem_ready tied 1: IF,ID,EX,WB,IF.
//     ir_we and pc_we in IF; rf_we in WB; retire once; retired_cnt=1.
//   - LW with mem_ready low 3 cycles in MEM: MEM held 4 cycles, mem_we=0,
//     then WB with rf_we=1. SW: mem_we=1 in MEM, no WB.
//   - BEQ with alu_zero=1 -> pc_we=1, pc_src=1 in EX.
//     alu_zero=0 -> pc_we=0. Both retire and return to IF.
//   - J: ID -> IF directly with pc_src=2. Opcode 6'h3F in ID -> ERR, err=1
//     held for 20 cycles until rst_n pulse.
//   - MEM_TIMEOUT=4, mem_ready stuck 0 in IF -> ERR after 4 cycles.
//     mem_ready=1 on the 4th cycle -> normal ID instead.
//   - halt_req raised in EX of ORI -> WB then HALT; drop halt_req -> IF next cycle.
//     rst_n low during MEM -> strobes 0 at once, state=IF, retired_cnt=0.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
package mc_sequencer_pkg;

  localparam int unsigned STATE_LEN = 3;

  typedef enum logic [STATE_LEN-1:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5,
    StErr  = 3'd6
  } state_e;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       rf_we;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ifetch;
    logic       retire;
  } strobes_t;

  // Ops that write the register file straight from the ALU result.
  function automatic logic is_alu_op(logic [5:0] op);
    return (op == OP_R_TYPE) || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface mc_sequencer_if;
  import mc_sequencer_pkg::*;

  logic [5:0]  opcode;
  logic        alu_zero;
  logic        mem_ready;
  logic        halt_req;
  state_e      state;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        ir_we;
  logic        rf_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ifetch;
  logic        retire;
  logic [31:0] retired_cnt;
  logic        err;

  modport master (
    input  opcode, alu_zero, mem_ready, halt_req,
    output state, pc_we, pc_src, ir_we, rf_we, mem_req, mem_we, mem_ifetch, retire,
    output retired_cnt, err
  );

  modport slave (
    output opcode, alu_zero, mem_ready, halt_req,
    input  state, pc_we, pc_src, ir_we, rf_we, mem_req, mem_we, mem_ifetch, retire,
    input  retired_cnt, err
  );
endinterface

// File: rtl/mc_seq_decode.sv
// Combinational next-state and strobe decode for the control sequencer.
module mc_seq_decode
  import mc_sequencer_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  input  logic       halt_req,
  input  logic       timeout,
  output state_e     next_state,
  output strobes_t   strobes
);

  // halt_req only matters once an instruction has fully completed.
  state_e boundary;
  assign boundary = halt_req ? StHalt : StIf;

  always_comb begin
    next_state = state;
    strobes    = '0;
    unique case (state)
      StIf: begin
        strobes.mem_req    = 1'b1;
        strobes.mem_ifetch = 1'b1;
        if (mem_ready) begin
          strobes.ir_we  = 1'b1;
          strobes.pc_we  = 1'b1;
          strobes.pc_src = PC_SRC_SEQ;
          next_state     = StId;
        end else if (timeout) begin
          next_state = StErr;
        end
      end
      StId: begin
        if (opcode == OP_J) begin
          strobes.pc_we  = 1'b1;
          strobes.pc_src = PC_SRC_JUMP;
          strobes.retire = 1'b1;
          next_state     = boundary;
        end else if (is_alu_op(opcode) || opcode == OP_LW || opcode == OP_SW ||
                     opcode == OP_BEQ) begin
          next_state = StEx;
        end else begin
          next_state = StErr;
        end
      end
      StEx: begin
        if (is_alu_op(opcode)) begin
          next_state = StWb;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          next_state = StMem;
        end else if (opcode == OP_BEQ) begin
          strobes.pc_we  = alu_zero;
          strobes.pc_src = PC_SRC_BRANCH;
          strobes.retire = 1'b1;
          next_state     = boundary;
        end else begin
          next_state = StErr;
        end
      end
      StMem: begin
        strobes.mem_req = 1'b1;
        strobes.mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_LW) begin
            next_state = StWb;
          end else if (opcode == OP_SW) begin
            strobes.retire = 1'b1;
            next_state     = boundary;
          end else begin
            next_state = StErr;
          end
        end else if (timeout) begin
          next_state = StErr;
        end
      end
      StWb: begin
        strobes.rf_we  = 1'b1;
        strobes.retire = 1'b1;
        next_state     = boundary;
      end
      StHalt: next_state = halt_req ? StHalt : StIf;
      StErr:  next_state = StErr;
      default: next_state = StErr;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer: state register, memory wait timeout and
// retired-instruction counter around the combinational decode.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_sequencer_if.master   bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      retired_cnt_q;
  logic             in_wait;
  logic             timeout;
  strobes_t         dec_strobes;
  strobes_t         strobes;

  assign in_wait = (state_q == StIf) || (state_q == StMem);
  // Fires on the cycle that would be the MEM_TIMEOUT-th consecutive stall.
  assign timeout = in_wait && !bus.mem_ready &&
                   (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  mc_seq_decode u_decode (
    .state      (state_q),
    .opcode     (bus.opcode),
    .alu_zero   (bus.alu_zero),
    .mem_ready  (bus.mem_ready),
    .halt_req   (bus.halt_req),
    .timeout    (timeout),
    .next_state (state_d),
    .strobes    (dec_strobes)
  );

  // Reset is asynchronous, so strobes must drop in the same cycle it asserts.
  always_comb begin
    strobes = dec_strobes;
    if (!rst_n) begin
      strobes.pc_we   = 1'b0;
      strobes.ir_we   = 1'b0;
      strobes.rf_we   = 1'b0;
      strobes.mem_req = 1'b0;
      strobes.mem_we  = 1'b0;
      strobes.retire  = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q + 1'b1;
    if (!in_wait || bus.mem_ready || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIf;
      wait_cnt_q    <= '0;
      retired_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (strobes.retire) begin
        retired_cnt_q <= retired_cnt_q + 32'd1;
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.pc_we       = strobes.pc_we;
  assign bus.pc_src      = strobes.pc_src;
  assign bus.ir_we       = strobes.ir_we;
  assign bus.rf_we       = strobes.rf_we;
  assign bus.mem_req     = strobes.mem_req;
  assign bus.mem_we      = strobes.mem_we;
  assign bus.mem_ifetch  = strobes.mem_ifetch;
  assign bus.retire      = strobes.retire;
  assign bus.retired_cnt = retired_cnt_q;
  assign bus.err         = (state_q == StErr);

endmodule
